forward_hazard_unit: RTL
========================

# forward_hazard_unit

Generates the forwarding selects, load-use stall and branch flush controls consumed by the Execute stage of the 16-bit pipelined datapath. It shadows the destination-register bookkeeping of the ID/EX, EX/MEM and MEM/WB pipeline registers. At the end of ID it computes registered `ForwardA`/`ForwardB` values, so they are stable for the whole EX cycle of the instruction. It sits beside the decode stage; its outputs drive the Execute operand muxes and the IF/ID and ID/EX register controls.

## Interface
Parameters:
- `REG_ADDR_W`, default 3, register address width (8 architectural registers).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs`  in  REG_ADDR_W  source A address of the instruction in ID.
- `id_rt`  in  REG_ADDR_W  source B address of the instruction in ID.
- `id_rd`  in  REG_ADDR_W  destination address of the ID instruction, after REGDST selection.
- `id_uses_rs`  in  1  ID instruction reads rs.
- `id_uses_rt`  in  1  ID instruction reads rt; 1 for stores even when ALUSRC=1.
- `id_regwrite`  in  1  ID instruction writes a register.
- `id_memread`  in  1  ID instruction is a load.
- `BRANCH_AND_ZERO`  in  1  taken branch resolved in EX this cycle.
- `ForwardA`  out  2  registered operand-A select: 00 reg file, 01 MEMWB, 10 EXMEM, 11 never driven.
- `ForwardB`  out  2  registered operand-B select, same encoding.
- `STALL`  out  1  combinational; when 1, PC and IF/ID hold.
- `IFID_FLUSH`  out  1  combinational; clears IF/ID.
- `IDEX_FLUSH`  out  1  combinational; loads a bubble into ID/EX.
- `EXMEM_RegRd`, `MEMWB_RegRd`  out  REG_ADDR_W  shadow destination addresses.
- `EXMEM_RegWrite`, `MEMWB_RegWrite`  out  1  shadow write enables.

## Operation
Shadow pipeline: three stages (IDEX, EXMEM, MEMWB), each holding {rd, regwrite, memread}. The stages advance every cycle: ID→IDEX→EXMEM→MEMWB.
- A bubble is {0, 0, 0}.
- A bubble enters IDEX when `STALL` or `IDEX_FLUSH` is 1.

Load-use stall:
- `STALL` = IDEX.memread & IDEX.regwrite & ((id_uses_rs & id_rs==IDEX.rd) | (id_uses_rt & id_rt==IDEX.rd)).
- `STALL` is forced to 0 when `BRANCH_AND_ZERO`=1.

Flush:
- `IFID_FLUSH` = `IDEX_FLUSH` = `BRANCH_AND_ZERO`.
- Flush wins over stall.

Forward computation, registered at the clock edge:
- Source A, when id_uses_rs: if IDEX.regwrite & IDEX.rd==id_rs → 10. Else if EXMEM.regwrite & EXMEM.rd==id_rs → 01. Else → 00.
- Source B uses the same rule with id_rt and id_uses_rt.
- These comparisons use the pre-edge shadow values. Those values become EXMEM and MEMWB when the ID instruction reaches EX.
- The most recent producer wins (10 over 01).
- 10 never selects a load: the stall guarantees the load has reached MEMWB by then.
- On a stall or flush cycle, `ForwardA`/`ForwardB` load 00 because the bubble enters EX.

The register file is write-through, so a producer that is in WB while the consumer is in ID needs no forwarding.

## Timing
- Reset: all shadow stages become bubbles. `ForwardA`=`ForwardB`=00. `STALL`/flush outputs are 0 while rst=1. Shadow outputs are 0.
- A reset mid-stall drops the stall the next cycle.
- Forward latency: the value is computed in ID and visible for exactly the one EX cycle.
- A load-use stall lasts exactly 1 cycle. The consumer then receives 01.
- Back-to-back dependences (two consecutive producers to the same rd): the younger one gives 10.
- A stall and a branch flush in the same cycle: flush only, no stall.

## Configuration
- `HAZARD_ZERO_REG_EN` defined: register 0 is hardwired. A match on rd==0 never forwards and never stalls.
- `HAZARD_ZERO_REG_EN` undefined: register 0 is treated like any other register.

## Structure
- Package `hazard_pkg`:
  - constants `FWD_REG`=2'b00, `FWD_MEMWB`=2'b01, `FWD_EXMEM`=2'b10, `FWD_RSVD`=2'b11;
  - `REG_ADDR_W`;
  - struct type `shadow_t` {rd, regwrite, memread}.
- Sub-module `hazard_stage_reg`: one shadow stage with synchronous rst and bubble-insert input, instantiated three times.

## Test plan
- ADD r3 (ID), then ADD r4←r3,r1 next → r4's `ForwardA`=10 during its EX; `ForwardB`=00.
- ADD r3; unrelated; SUB r5←r2,r3 → `ForwardB`=01 in SUB's EX.
- LW r2; ADD r6←r2,r2 → `STALL`=1 for 1 cycle with bubble in IDEX; then `ForwardA`=`ForwardB`=01.
- LW r2 with a dependent in ID and `BRANCH_AND_ZERO`=1 in the same cycle → `STALL`=0, `IFID_FLUSH`=`IDEX_FLUSH`=1; `ForwardA`/`ForwardB` load 00.
- ADD r0; ADD r1←r0 → 00 with `HAZARD_ZERO_REG_EN` defined, 10 without it.
- Assert rst during a stall → next cycle all outputs 0 and shadow registers cleared.

Source files
------------

// File: rtl/forward_hazard_unit_pkg.sv
// hazard_pkg: shared types and constants for forward_hazard_unit.
//   FWD_*    : operand-select encodings driven on ForwardA/ForwardB
//   shadow_t : one shadow pipeline stage {rd, regwrite, memread}
package hazard_pkg;

    localparam int REG_ADDR_W = 3;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_RSVD  = 2'b11;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } shadow_t;

endpackage

// File: rtl/forward_hazard_unit_if.sv
// forward_hazard_unit_if: decode-side inputs and hazard/forward outputs.
//   master : drives the ID-stage fields and BRANCH_AND_ZERO, reads controls
//   slave  : the hazard unit itself
interface forward_hazard_unit_if #(
    parameter int REG_ADDR_W = 3
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  BRANCH_AND_ZERO;

    logic [1:0]            ForwardA;
    logic [1:0]            ForwardB;
    logic                  STALL;
    logic                  IFID_FLUSH;
    logic                  IDEX_FLUSH;
    logic [REG_ADDR_W-1:0] EXMEM_RegRd;
    logic [REG_ADDR_W-1:0] MEMWB_RegRd;
    logic                  EXMEM_RegWrite;
    logic                  MEMWB_RegWrite;

    modport master (
        output id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_regwrite, id_memread, BRANCH_AND_ZERO,
        input  ForwardA, ForwardB, STALL, IFID_FLUSH, IDEX_FLUSH,
               EXMEM_RegRd, MEMWB_RegRd, EXMEM_RegWrite, MEMWB_RegWrite
    );

    modport slave (
        input  id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_regwrite, id_memread, BRANCH_AND_ZERO,
        output ForwardA, ForwardB, STALL, IFID_FLUSH, IDEX_FLUSH,
               EXMEM_RegRd, MEMWB_RegRd, EXMEM_RegWrite, MEMWB_RegWrite
    );

endinterface

// File: rtl/forward_hazard_unit_stage_reg.sv
// hazard_stage_reg: one shadow pipeline stage.
//   clk, rst : clock and synchronous active-high reset
//   bubble   : load an empty slot instead of d
//   d / q    : incoming / held shadow_t
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    bubble,
    input  shadow_t d,
    output shadow_t q
);

    always_ff @(posedge clk) begin
        if (rst || bubble) q <= '0;
        else               q <= d;
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: forwarding selects, load-use stall and branch flush
// for the Execute stage. Tracks destination bookkeeping of ID/EX, EX/MEM and
// MEM/WB in three shadow stages and registers ForwardA/ForwardB at the end
// of ID so they are stable throughout the consumer's EX cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : forward_hazard_unit_if.slave (ID fields in; selects,
//              STALL, flushes and shadow EXMEM/MEMWB state out)
// Build option: HAZARD_ZERO_REG_EN -- register 0 is hardwired, so a match
// on r0 neither forwards nor stalls.
// REG_ADDR_W must equal hazard_pkg::REG_ADDR_W (shadow_t is sized by it).
module forward_hazard_unit
    import hazard_pkg::shadow_t, hazard_pkg::FWD_REG,
           hazard_pkg::FWD_MEMWB, hazard_pkg::FWD_EXMEM;
#(
    parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W
)(
    input  logic                   clk,
    input  logic                   rst,
    forward_hazard_unit_if.slave   bus
);

`ifdef HAZARD_ZERO_REG_EN
    localparam bit ZERO_HW = 1'b1;
`else
    localparam bit ZERO_HW = 1'b0;
`endif

    shadow_t    id_sh, idex_q, exmem_q, memwb_q;
    logic       stall, flush, bubble;
    logic [1:0] fa_d, fb_d, fa_q, fb_q;

    // Address match that honours the hardwired-zero option.
    function automatic logic hit(input logic [REG_ADDR_W-1:0] a,
                                 input logic [REG_ADDR_W-1:0] b);
        hit = (a == b) && !(ZERO_HW && (a == '0));
    endfunction

    // Most recent producer wins: the one now in EX (arrives in EX/MEM when
    // the consumer is in EX), then the one now in MEM.
    function automatic logic [1:0] sel(input logic use_src,
                                       input logic [REG_ADDR_W-1:0] src,
                                       input shadow_t ex,
                                       input shadow_t mem);
        if (use_src && ex.regwrite && hit(ex.rd, src))        sel = FWD_EXMEM;
        else if (use_src && mem.regwrite && hit(mem.rd, src)) sel = FWD_MEMWB;
        else                                                  sel = FWD_REG;
    endfunction

    assign id_sh = '{rd: bus.id_rd, regwrite: bus.id_regwrite,
                     memread: bus.id_memread};

    // A taken branch overrides the load-use stall; both collapse under reset.
    assign flush = bus.BRANCH_AND_ZERO & ~rst;
    assign stall = ~rst & ~bus.BRANCH_AND_ZERO & idex_q.memread & idex_q.regwrite &
                   ((bus.id_uses_rs & hit(idex_q.rd, bus.id_rs)) |
                    (bus.id_uses_rt & hit(idex_q.rd, bus.id_rt)));
    assign bubble = stall | flush;

    hazard_stage_reg u_idex (
        .clk(clk), .rst(rst), .bubble(bubble), .d(id_sh), .q(idex_q)
    );
    hazard_stage_reg u_exmem (
        .clk(clk), .rst(rst), .bubble(1'b0), .d(idex_q), .q(exmem_q)
    );
    hazard_stage_reg u_memwb (
        .clk(clk), .rst(rst), .bubble(1'b0), .d(exmem_q), .q(memwb_q)
    );

    always_comb begin
        fa_d = sel(bus.id_uses_rs, bus.id_rs, idex_q, exmem_q);
        fb_d = sel(bus.id_uses_rt, bus.id_rt, idex_q, exmem_q);
    end

    // A bubble is what reaches EX on stall/flush, so it gets no forwarding.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            fa_q <= FWD_REG;
            fb_q <= FWD_REG;
        end else begin
            fa_q <= fa_d;
            fb_q <= fb_d;
        end
    end

    // Only regwrite/rd of the later stages are observable.
    logic unused_memread;
    assign unused_memread = exmem_q.memread ^ memwb_q.memread;

    assign bus.ForwardA       = fa_q;
    assign bus.ForwardB       = fb_q;
    assign bus.STALL          = stall;
    assign bus.IFID_FLUSH     = flush;
    assign bus.IDEX_FLUSH     = flush;
    assign bus.EXMEM_RegRd    = exmem_q.rd;
    assign bus.MEMWB_RegRd    = memwb_q.rd;
    assign bus.EXMEM_RegWrite = exmem_q.regwrite;
    assign bus.MEMWB_RegWrite = memwb_q.regwrite;

endmodule
